// File: rtl/e_alu_arbiter.sv
// Two-port arbiter feeding one shared integer ALU with a one-entry result register.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration (default: port 0 fixed priority).

package e_alu_pkg;
  localparam logic [2:0] GRAND_OP_INT = 3'd0;
  localparam logic [2:0] GRAND_OP_LI  = 3'd1;
  localparam logic [2:0] GRAND_OP_CMP = 3'd2;

  localparam logic [2:0] INT_ADD = 3'd0;
  localparam logic [2:0] INT_SUB = 3'd1;
  localparam logic [2:0] INT_AND = 3'd2;
  localparam logic [2:0] INT_OR  = 3'd3;
  localparam logic [2:0] INT_XOR = 3'd4;
  localparam logic [2:0] INT_SLL = 3'd5;
  localparam logic [2:0] INT_SRL = 3'd6;
  localparam logic [2:0] INT_SRA = 3'd7;

  localparam logic [2:0] LI_LUI   = 3'd0;
  localparam logic [2:0] LI_AUIPC = 3'd1;
  localparam logic [2:0] LI_LINK  = 3'd2;

  localparam logic [2:0] CMP_SLT  = 3'd0;
  localparam logic [2:0] CMP_SLTU = 3'd1;
  localparam logic [2:0] CMP_EQ   = 3'd2;
  localparam logic [2:0] CMP_NE   = 3'd3;
  localparam logic [2:0] CMP_SGE  = 3'd4;
  localparam logic [2:0] CMP_SGEU = 3'd5;
endpackage

module e_alu
  import e_alu_pkg::*;
(
  input  logic [2:0]  grand_op,
  input  logic [2:0]  op,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  input  logic [31:0] pc,
  output logic [31:0] result
);
  logic [4:0] shamt;
  assign shamt = r1[4:0];

  always_comb begin
    // NOTE: default first so every path assigns result; otherwise a latch is inferred.
    result = '0;
    unique case (grand_op)
      GRAND_OP_INT: begin
        unique case (op)
          INT_ADD: result = r0 + r1;
          INT_SUB: result = r0 - r1;
          INT_AND: result = r0 & r1;
          INT_OR:  result = r0 | r1;
          INT_XOR: result = r0 ^ r1;
          INT_SLL: result = r0 << shamt;
          INT_SRL: result = r0 >> shamt;
          INT_SRA: result = $unsigned($signed(r0) >>> shamt);
          default: result = '0;
        endcase
      end
      GRAND_OP_LI: begin
        unique case (op)
          LI_LUI:   result = {r1[19:0], 12'h000};
          LI_AUIPC: result = pc + {r1[19:0], 12'h000};
          LI_LINK:  result = pc + 32'd4;
          default:  result = '0;
        endcase
      end
      GRAND_OP_CMP: begin
        unique case (op)
          CMP_SLT:  result = {31'b0, $signed(r0) < $signed(r1)};
          CMP_SLTU: result = {31'b0, r0 < r1};
          CMP_EQ:   result = {31'b0, r0 == r1};
          CMP_NE:   result = {31'b0, r0 != r1};
          CMP_SGE:  result = {31'b0, $signed(r0) >= $signed(r1)};
          CMP_SGEU: result = {31'b0, r0 >= r1};
          default:  result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end
endmodule

module e_alu_arbiter #(
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][31:0]      req_r0_i,
  input  logic [1:0][31:0]      req_r1_i,
  input  logic [1:0][31:0]      req_pc_i,
  input  logic [1:0][2:0]       req_grand_op_i,
  input  logic [1:0][2:0]       req_op_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [31:0]           res_data_o,
  output logic [TAG_W-1:0]      res_tag_o,
  output logic                  res_src_o
);
  logic        grant;
  logic        can_accept;
  logic        accept;
  logic [31:0] alu_result;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // Contention alternates; a lone requester always wins.
  always_comb begin
    grant = req_valid_i[1];
    if (&req_valid_i) grant = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  assign grant = ~req_valid_i[0] & req_valid_i[1];
`endif

  assign can_accept = ~flush_i & (~res_valid_o | res_ready_i);

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = can_accept & req_valid_i[grant];
  end

  assign accept = |req_ready_o;

  e_alu u_alu (
    .grand_op (req_grand_op_i[grant]),
    .op       (req_op_i[grant]),
    .r0       (req_r0_i[grant]),
    .r1       (req_r1_i[grant]),
    .pc       (req_pc_i[grant]),
    .result   (alu_result)
  );

  // Data fields only change on accept; drain and flush just drop the valid bit.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (!rst_n) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_tag_o   <= '0;
      res_src_o   <= 1'b0;
    end else if (accept) begin
      res_valid_o <= 1'b1;
      res_data_o  <= alu_result;
      res_tag_o   <= req_tag_i[grant];
      res_src_o   <= grant;
    end else if (flush_i || res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_e_alu_arbiter.sv
// Self-checking bench for e_alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (honours ALU_ARB_RR_EN).

module tb_e_alu_arbiter;
  import e_alu_pkg::*;

  localparam int TAG_W = 6;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush_i = 1'b0;
  logic [1:0]            req_valid_i = '0;
  logic [1:0]            req_ready_o;
  logic [1:0][31:0]      req_r0_i = '0;
  logic [1:0][31:0]      req_r1_i = '0;
  logic [1:0][31:0]      req_pc_i = '0;
  logic [1:0][2:0]       req_grand_op_i = '0;
  logic [1:0][2:0]       req_op_i = '0;
  logic [1:0][TAG_W-1:0] req_tag_i = '0;
  logic                  res_valid_o;
  logic                  res_ready_i = 1'b1;
  logic [31:0]           res_data_o;
  logic [TAG_W-1:0]      res_tag_o;
  logic                  res_src_o;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the result register should hold, and who last won.
  bit             m_valid;
  logic [31:0]    m_data;
  logic [TAG_W-1:0] m_tag;
  bit             m_src;
  bit             m_last;
  int             last_acc;

  always #5 clk = ~clk;

  e_alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_r0_i       (req_r0_i),
    .req_r1_i       (req_r1_i),
    .req_pc_i       (req_pc_i),
    .req_grand_op_i (req_grand_op_i),
    .req_op_i       (req_op_i),
    .req_tag_i      (req_tag_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_data_o     (res_data_o),
    .res_tag_o      (res_tag_o),
    .res_src_o      (res_src_o)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] gop, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc);
    int unsigned sh;
    sh = b % 32;
    if (gop == GRAND_OP_INT) begin
      if (op == INT_ADD) return a + b;
      if (op == INT_SUB) return a - b;
      if (op == INT_AND) return a & b;
      if (op == INT_OR)  return a | b;
      if (op == INT_XOR) return a ^ b;
      if (op == INT_SLL) return a << sh;
      if (op == INT_SRL) return a >> sh;
      if (op == INT_SRA) return a[31] ? ~((~a) >> sh) : a >> sh;
    end else if (gop == GRAND_OP_LI) begin
      if (op == LI_LUI)   return (b % (1 << 20)) * 4096;
      if (op == LI_AUIPC) return pc + (b % (1 << 20)) * 4096;
      if (op == LI_LINK)  return pc + 4;
    end else if (gop == GRAND_OP_CMP) begin
      if (op == CMP_SLT)  return (int'(a) < int'(b)) ? 1 : 0;
      if (op == CMP_SLTU) return (a < b) ? 1 : 0;
      if (op == CMP_EQ)   return (a == b) ? 1 : 0;
      if (op == CMP_NE)   return (a != b) ? 1 : 0;
      if (op == CMP_SGE)  return (int'(a) >= int'(b)) ? 1 : 0;
      if (op == CMP_SGEU) return (a >= b) ? 1 : 0;
    end
    return 32'd0;
  endfunction

  function automatic bit ref_grant();
    if (req_valid_i == 2'b11) return RR ? !m_last : 1'b0;
    return req_valid_i[1];
  endfunction

  function automatic logic [1:0] ref_ready();
    bit g;
    logic [1:0] r;
    g = ref_grant();
    r = 2'b00;
    if (!flush_i && (!m_valid || res_ready_i) && req_valid_i[g]) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and move the model forward by one transaction rule set.
  task automatic step();
    bit g;
    bit acc;
    logic [1:0] r;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    g = ref_grant();
    r = ref_ready();
    acc = r[g];
    d = ref_alu(req_grand_op_i[g], req_op_i[g], req_r0_i[g], req_r1_i[g], req_pc_i[g]);
    t = req_tag_i[g];
    @(posedge clk);
    #1;
    last_acc = -1;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_last = 1;
    end else if (acc) begin
      m_valid = 1; m_data = d; m_tag = t; m_src = g; m_last = g;
      last_acc = int'(g);
    end else if (flush_i || res_ready_i) begin
      m_valid = 0;
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] gop, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_grand_op_i[p] = gop;
    req_op_i[p]       = op;
    req_r0_i[p]       = a;
    req_r1_i[p]       = b;
    req_pc_i[p]       = 32'h0000_1000;
    req_tag_i[p]      = tag;
  endtask

  task automatic rand_port(input int p);
    req_grand_op_i[p] = 3'($urandom_range(0, 2));
    req_op_i[p]       = 3'($urandom_range(0, 7));
    req_r0_i[p]       = $urandom;
    req_r1_i[p]       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    req_pc_i[p]       = $urandom;
    req_tag_i[p]      = TAG_W'($urandom);
  endtask

  task automatic idle();
    req_valid_i = 2'b00;
    flush_i     = 1'b0;
    res_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", res_valid_o); end
    checks++; if (res_data_o !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h expected 0", res_data_o); end
    checks++; if (res_tag_o !== '0) begin failures++; $display("FAIL reset_tag: got %0h expected 0", res_tag_o); end
    checks++; if (res_src_o !== 1'b0) begin failures++; $display("FAIL reset_src: got %0b expected 0", res_src_o); end
    #1;
    checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL reset_ready_idle: got %b expected 00", req_ready_o); end
    req_valid_i = 2'b11; flush_i = 1'b1; #1;
    checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL reset_ready_flush: got %b expected 00", req_ready_o); end
    flush_i = 1'b0; #1;
    checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL reset_first_grant: got %b expected 01", req_ready_o); end
    idle();
  endtask

  task automatic test_single_add();
    idle();
    set_port(0, GRAND_OP_INT, INT_ADD, 32'd5, 32'd7, 6'd3);
    req_valid_i = 2'b01; #1;
    checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL add_ready: got %b expected 01", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL add_valid: got %0b expected 1", res_valid_o); end
    checks++; if (res_data_o !== 32'd12) begin failures++; $display("FAIL add_data: got %0d expected 12", res_data_o); end
    checks++; if (res_tag_o !== 6'd3) begin failures++; $display("FAIL add_tag: got %0d expected 3", res_tag_o); end
    checks++; if (res_src_o !== 1'b0) begin failures++; $display("FAIL add_src: got %0b expected 0", res_src_o); end
    step();
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL add_drained: got %0b expected 0", res_valid_o); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_r;
    bit exp_g;
    do_reset();
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rand_port(0);
      rand_port(1);
      exp_g = RR ? bit'(i % 2) : 1'b0;
      exp_r = exp_g ? 2'b10 : 2'b01;
      #1;
      checks++; if (req_ready_o !== exp_r) begin failures++; $display("FAIL arb_ready[%0d]: got %b expected %b", i, req_ready_o, exp_r); end
      step();
      checks++; if (res_valid_o !== 1'b1 || res_src_o !== exp_g) begin failures++; $display("FAIL arb_result[%0d]: got valid=%0b src=%0b expected valid=1 src=%0b", i, res_valid_o, res_src_o, exp_g); end
      checks++; if (res_data_o !== m_data || res_tag_o !== m_tag) begin failures++; $display("FAIL arb_data[%0d]: got %h/%h expected %h/%h", i, res_data_o, res_tag_o, m_data, m_tag); end
    end
    idle();
    step();
  endtask

  task automatic test_backpressure();
    idle();
    set_port(0, GRAND_OP_INT, INT_ADD, 32'd100, 32'd23, 6'd1);
    req_valid_i = 2'b01;
    step();
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'd123) begin failures++; $display("FAIL bp_first: got valid=%0b data=%0d expected 1/123", res_valid_o, res_data_o); end
    res_ready_i = 1'b0;
    set_port(1, GRAND_OP_LI, LI_LUI, 32'd0, 32'h0001_2345, 6'd2);
    req_valid_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready_o); end
      step();
      checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'd123) begin failures++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d expected 1/123", i, res_valid_o, res_data_o); end
    end
    res_ready_i = 1'b1; #1;
    checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL bp_release_ready: got %b expected 10", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'h1234_5000 || res_src_o !== 1'b1) begin failures++; $display("FAIL bp_lui: got valid=%0b data=%h src=%0b expected 1/12345000/1", res_valid_o, res_data_o, res_src_o); end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    req_valid_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      rand_port(0);
      step();
      checks++; if (last_acc !== 0 || res_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got valid=%0b acc=%0d expected 1/0", i, res_valid_o, last_acc); end
      checks++; if (res_data_o !== m_data || res_tag_o !== m_tag) begin failures++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, res_data_o, res_tag_o, m_data, m_tag); end
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    idle();
    set_port(0, GRAND_OP_INT, INT_ADD, 32'd1, 32'd2, 6'd9);
    req_valid_i = 2'b01;
    step();
    res_ready_i = 1'b0;
    set_port(0, GRAND_OP_INT, INT_ADD, 32'd10, 32'd20, 6'd10);
    flush_i = 1'b1; #1;
    checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL flush_ready: got %b expected 00", req_ready_o); end
    step();
    flush_i = 1'b0;
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL flush_kill: got %0b expected 0", res_valid_o); end
    #1;
    checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL flush_after_ready: got %b expected 01", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'd30 || res_tag_o !== 6'd10) begin failures++; $display("FAIL flush_reissue: got valid=%0b data=%0d tag=%0d expected 1/30/10", res_valid_o, res_data_o, res_tag_o); end
    res_ready_i = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_stream();
    idle();
    set_port(0, GRAND_OP_INT, INT_XOR, 32'hdead_beef, 32'h0f0f_0f0f, 6'd33);
    req_valid_i = 2'b01;
    step();
    res_ready_i = 1'b0;
    req_valid_i = 2'b11;
    rst_n = 1'b0;
    step();
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %0b expected 0", res_valid_o); end
    checks++; if (res_data_o !== 32'd0 || res_tag_o !== '0 || res_src_o !== 1'b0) begin failures++; $display("FAIL rst_mid_fields: got %h/%h/%0b expected 0/0/0", res_data_o, res_tag_o, res_src_o); end
    rst_n = 1'b1;
    res_ready_i = 1'b1; #1;
    checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rst_mid_grant: got %b expected 01", req_ready_o); end
    step();
    checks++; if (res_valid_o !== 1'b1 || res_src_o !== 1'b0) begin failures++; $display("FAIL rst_mid_first: got valid=%0b src=%0b expected 1/0", res_valid_o, res_src_o); end
    idle();
    step();
  endtask

  task automatic test_random();
    logic [1:0] exp_r;
    for (int i = 0; i < 400; i++) begin
      rand_port(0);
      rand_port(1);
      req_valid_i = 2'($urandom);
      flush_i     = ($urandom_range(0, 9) == 0);
      res_ready_i = ($urandom_range(0, 9) < 7);
      exp_r = ref_ready();
      #1;
      checks++; if (req_ready_o !== exp_r) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready_o, exp_r); end
      step();
      checks++; if (res_valid_o !== m_valid) begin failures++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", i, res_valid_o, m_valid); end
      checks++; if (res_data_o !== m_data || res_tag_o !== m_tag || res_src_o !== m_src) begin failures++; $display("FAIL rand_result[%0d]: got %h/%h/%0b expected %h/%h/%0b", i, res_data_o, res_tag_o, res_src_o, m_data, m_tag, m_src); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_arbitration();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
